// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// instruction fields, ALU operations and datapath mux selects.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXE   = 4'd6,
        S_R_WB    = 4'd7,
        S_I_EXE   = 4'd8,
        S_I_WB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JTGT   = 2'b10;
    localparam logic [1:0] PCSRC_REG_A  = 2'b11;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_R31 = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type func field to ALU operation map; valid also covers jr so that
// DECODE can flag any other func as illegal.
module mc_alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_ctrl,
    output logic       func_valid
);

    always_comb begin
        alu_ctrl   = ALU_ADD;
        func_valid = 1'b1;
        case (func)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_JR:   alu_ctrl = ALU_ADD;
            default: func_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode, execute,
// memory and writeback, stalling on mem_ready during memory accesses.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] data_to_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [2:0] r_alu_ctrl;
    logic       func_valid;

    mc_alu_decoder u_alu_dec (
        .func       (func),
        .alu_ctrl   (r_alu_ctrl),
        .func_valid (func_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_ctrl      = ALU_AND;
        pc_src        = PCSRC_ALU;
        reg_dst       = RDST_RT;
        data_to_write = WD_ALUOUT;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures PC+4 + (imm<<2) for a possible beq
                alu_src_b = SRCB_IMM_SH2;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (func == FN_JR)   state_d = S_JR;
                        else if (func_valid) state_d = S_R_EXE;
                        else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:     state_d = S_MEM_ADR;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXE;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_dst       = RDST_RT;
                data_to_write = WD_MDR;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_ctrl  = r_alu_ctrl;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst       = RDST_RD;
                data_to_write = WD_ALUOUT;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_dst       = RDST_RT;
                data_to_write = WD_ALUOUT;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_ctrl  = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JTGT;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC already advanced in FETCH, so PC is the link value
                pc_src        = PCSRC_JTGT;
                pc_write      = 1'b1;
                reg_dst       = RDST_R31;
                data_to_write = WD_PC;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_JR: begin
                pc_src   = PCSRC_REG_A;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction expected output cycles
// are queued up front, then popped and compared one clock at a time.
module tb_mc_controller;

    typedef struct packed {
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] data_to_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       i_or_d, alu_src_a, mem_read, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_b, pc_src, reg_dst, data_to_write;
    logic [2:0] alu_ctrl;

    int vectors = 0;
    int miscompares = 0;
    int ir_pulses = 0;

    out_t         q_exp[$];
    logic [1:0]   q_in[$];
    string        q_tag[$];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .reg_dst(reg_dst), .data_to_write(data_to_write), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .illegal(illegal)
    );

    function automatic out_t actual();
        return {i_or_d, alu_src_a, alu_src_b, alu_ctrl, pc_src, reg_dst,
                data_to_write, mem_read, mem_write, ir_write, pc_write,
                reg_write, illegal};
    endfunction

    function automatic out_t e_fetch(input logic rdy);
        out_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
        o.ir_write = rdy;  o.pc_write = rdy;
        return o;
    endfunction
    function automatic out_t e_decode(input logic ill);
        out_t o = '0;
        o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; o.illegal = ill;
        return o;
    endfunction
    function automatic out_t e_exe(input logic [1:0] srcb, input logic [2:0] ctrl);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = srcb; o.alu_ctrl = ctrl;
        return o;
    endfunction
    function automatic out_t e_mem(input logic wr);
        out_t o = '0;
        o.i_or_d = 1'b1; o.mem_read = ~wr; o.mem_write = wr;
        return o;
    endfunction
    function automatic out_t e_wb(input logic [1:0] dst, input logic [1:0] wd);
        out_t o = '0;
        o.reg_dst = dst; o.data_to_write = wd; o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic out_t e_pc(input logic [1:0] src, input logic wr);
        out_t o = '0;
        o.pc_src = src; o.pc_write = wr;
        return o;
    endfunction
    function automatic out_t e_branch(input logic z);
        out_t o = e_exe(2'b00, 3'b110);
        o.pc_src = 2'b01; o.pc_write = z;
        return o;
    endfunction
    function automatic out_t e_jal();
        out_t o = e_wb(2'b10, 2'b10);
        o.pc_src = 2'b10; o.pc_write = 1'b1;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic z, input out_t e, input string tag);
        q_in.push_back({rdy, z});
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    task automatic check(input out_t exp, input string tag);
        out_t act = actual();
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic drain();
        while (q_exp.size() > 0) begin
            logic [1:0] in_v = q_in.pop_front();
            out_t       e    = q_exp.pop_front();
            string      t    = q_tag.pop_front();
            mem_ready = in_v[1];
            zero      = in_v[0];
            #1;
            if (ir_write === 1'b1) ir_pulses++;
            check(e, t);
            @(negedge clk);
        end
    endtask

    task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        func   = fn;
    endtask

    logic [5:0] r_func[5];
    logic [2:0] r_ctrl[5];

    initial begin
        r_func = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r_ctrl = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

        @(negedge clk);
        #1 check(e_fetch(1'b0), "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles
        set_inst(6'b100011, 6'd0);
        ir_pulses = 0;
        push(0, 0, e_fetch(0), "lw_fetch_wait0");
        push(0, 0, e_fetch(0), "lw_fetch_wait1");
        push(1, 0, e_fetch(1), "lw_fetch");
        push(1, 0, e_decode(0), "lw_decode");
        push(1, 0, e_exe(2'b10, 3'b010), "lw_mem_adr");
        push(0, 0, e_mem(0), "lw_mem_rd_wait0");
        push(0, 0, e_mem(0), "lw_mem_rd_wait1");
        push(1, 0, e_mem(0), "lw_mem_rd");
        push(1, 0, e_wb(2'b00, 2'b01), "lw_mem_wb");
        drain();
        begin
            vectors++;
            assert (ir_pulses == 1) else begin
                miscompares++;
                $error("FAIL lw_ir_pulses: observed %0d expected 1", ir_pulses);
            end
        end

        set_inst(6'b101011, 6'd0);
        push(1, 0, e_fetch(1), "sw_fetch");
        push(1, 0, e_decode(0), "sw_decode");
        push(1, 0, e_exe(2'b10, 3'b010), "sw_mem_adr");
        push(1, 0, e_mem(1), "sw_mem_wr");
        drain();

        for (int i = 0; i < 5; i++) begin
            set_inst(6'b000000, r_func[i]);
            push(1, 0, e_fetch(1), "r_fetch");
            push(1, 0, e_decode(0), "r_decode");
            push(1, 0, e_exe(2'b00, r_ctrl[i]), "r_exe_alu_ctrl");
            push(1, 0, e_wb(2'b01, 2'b00), "r_wb");
            drain();
        end

        set_inst(6'b001000, 6'b111111);
        push(1, 0, e_fetch(1), "addi_fetch");
        push(1, 0, e_decode(0), "addi_decode");
        push(1, 0, e_exe(2'b10, 3'b010), "addi_exe");
        push(1, 0, e_wb(2'b00, 2'b00), "addi_wb");
        drain();
        set_inst(6'b001010, 6'b000000);
        push(1, 0, e_fetch(1), "slti_fetch");
        push(1, 0, e_decode(0), "slti_decode");
        push(1, 0, e_exe(2'b10, 3'b111), "slti_exe");
        push(1, 0, e_wb(2'b00, 2'b00), "slti_wb");
        drain();

        set_inst(6'b000100, 6'd0);
        push(1, 0, e_fetch(1), "beq1_fetch");
        push(1, 0, e_decode(0), "beq1_decode");
        push(1, 1, e_branch(1), "beq_taken");
        push(1, 0, e_fetch(1), "beq2_fetch");
        push(1, 0, e_decode(0), "beq2_decode");
        push(1, 0, e_branch(0), "beq_not_taken");
        drain();

        set_inst(6'b000010, 6'd0);
        push(1, 0, e_fetch(1), "j_fetch");
        push(1, 0, e_decode(0), "j_decode");
        push(1, 0, e_pc(2'b10, 1), "j_jump");
        drain();
        set_inst(6'b000011, 6'd0);
        push(1, 0, e_fetch(1), "jal_fetch");
        push(1, 0, e_decode(0), "jal_decode");
        push(1, 0, e_jal(), "jal_cycle");
        drain();
        set_inst(6'b000000, 6'b001000);
        push(1, 0, e_fetch(1), "jr_fetch_after_jal");
        push(1, 0, e_decode(0), "jr_decode");
        push(1, 0, e_pc(2'b11, 1), "jr_cycle");
        drain();

        set_inst(6'b000000, 6'b000111);
        push(1, 0, e_fetch(1), "badfunc_fetch");
        push(1, 0, e_decode(1), "badfunc_illegal");
        drain();
        set_inst(6'b111111, 6'b100000);
        push(1, 0, e_fetch(1), "badop_fetch_after_illegal");
        push(1, 0, e_decode(1), "badop_illegal");
        drain();

        // Reset during a stalled store must take effect without a clock edge
        set_inst(6'b101011, 6'd0);
        push(1, 0, e_fetch(1), "rst_sw_fetch");
        push(1, 0, e_decode(0), "rst_sw_decode");
        push(1, 0, e_exe(2'b10, 3'b010), "rst_sw_mem_adr");
        push(0, 0, e_mem(1), "rst_sw_mem_wr_wait");
        drain();
        mem_ready = 1'b0;
        #2 check(e_mem(1), "rst_sw_still_waiting");
        rst = 1'b1;
        #1 check(e_fetch(0), "rst_async_fetch");
        @(negedge clk);
        check(e_fetch(0), "rst_held_fetch");
        rst = 1'b0;
        set_inst(6'b000010, 6'd0);
        push(1, 0, e_fetch(1), "post_rst_fetch");
        push(1, 0, e_decode(0), "post_rst_decode");
        push(1, 0, e_pc(2'b10, 1), "post_rst_jump");
        push(0, 0, e_fetch(0), "final_fetch");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
